// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO, sync-read RAM, registered flags/count.
// Define PARAM_FIFO_ERR_EN for sticky overflow/underflow flags.
module param_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 14,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_nxt;
  logic [CW-1:0] rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          wr_ok;
  logic          rd_ok;

  // Occupancy is the pointer distance; the extra MSB separates full from empty.
  always_comb begin
    wr_ok   = reset & enable & write & ~full;
    rd_ok   = reset & enable & read & ~empty;
    wr_nxt  = wr_ptr + CW'(wr_ok);
    rd_nxt  = rd_ptr + CW'(rd_ok);
    cnt_nxt = wr_nxt - rd_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      data_valid   <= 1'b0;
    end else begin
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      count        <= cnt_nxt;
      full         <= (cnt_nxt == FULL_C);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      data_valid   <= rd_ok;
    end
  end

  // RAM array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

`ifdef PARAM_FIFO_ERR_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enable & write & full) begin
        overflow <= 1'b1;
      end
      if (enable & read & empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed steps against a queue model and a
// scoreboard of expected read data.
module tb_param_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          read = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  param_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_THRESH(AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .write(write),
    .data_in(data_in),
    .read(read),
    .data_out(data_out),
    .data_valid(data_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] last_out = '0;
  logic          exp_dv = 1'b0;
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;
  logic [DW-1:0] want;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en,
                      input logic w, input logic [DW-1:0] d,
                      input logic r);
    int n;
    logic wa;
    logic ra;
    reset = rst;
    enable = en;
    write = w;
    data_in = d;
    read = r;
    n = model_q.size();
    if (!rst) begin
      model_q.delete();
      sb_q.delete();
      last_out = '0;
      exp_dv = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      wa = en & w & (n < DEPTH);
      ra = en & r & (n > 0);
`ifdef PARAM_FIFO_ERR_EN
      if (en & w & (n == DEPTH)) m_ov = 1'b1;
      if (en & r & (n == 0)) m_un = 1'b1;
`endif
      exp_dv = ra;
      if (ra) begin
        last_out = model_q.pop_front();
        sb_q.push_back(last_out);
      end
      if (wa) model_q.push_back(d);
    end
    @(posedge clock);
    #1;
    n = model_q.size();
    chk("data_valid", 32'(data_valid), 32'(exp_dv));
    if (data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        want = sb_q.pop_front();
        chk("rd_data", 32'(data_out), 32'(want));
      end
    end
    chk("data_out_hold", 32'(data_out), 32'(last_out));
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  endtask

  initial begin
    // Reset held for two cycles
    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'hAA, 1);

    // Fill 0x01..0x10, then drain
    for (int i = 1; i <= 16; i++) step(1, 1, 1, 8'(i), 0);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 8'h00, 1);
    step(1, 1, 0, 8'h00, 0);

    // Pointer wrap
    for (int i = 0; i < 10; i++) step(1, 1, 1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 8'h00, 1);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) step(1, 1, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 8'(8'h70 + i), 1);
    chk("rw_count5", 32'(count), 32'(5));
    for (int i = 0; i < 11; i++) step(1, 1, 1, 8'(8'h80 + i), 0);
    chk("full_before_rw", 32'(full), 32'(1));

    // Overflow: write while full
    step(1, 1, 1, 8'hEE, 0);
    chk("ovf_count16", 32'(count), 32'(16));

    // Read+write at full accepts only the read
    step(1, 1, 1, 8'hEF, 1);
    chk("rw_full_cnt", 32'(count), 32'(15));
    for (int i = 0; i < 15; i++) step(1, 1, 0, 8'h00, 1);

    // Underflow, then read+write at empty accepts only the write
    step(1, 1, 0, 8'h00, 1);
    step(1, 1, 1, 8'h99, 1);
    chk("rw_empty_cnt", 32'(count), 32'(1));
    chk("rw_empty_dv", 32'(data_valid), 32'(0));
    step(1, 1, 0, 8'h00, 1);
    step(1, 1, 0, 8'h00, 0);

    // Enable low: requests ignored
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'(8'hA0 + i), 0);
    step(1, 0, 1, 8'hB0, 0);
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 1, 8'hB1, 1);
    chk("en_low_cnt", 32'(count), 32'(3));

    // Reset mid-operation at count 9
    for (int i = 0; i < 6; i++) step(1, 1, 1, 8'(8'hC0 + i), 0);
    chk("pre_rst_cnt", 32'(count), 32'(9));
    step(0, 1, 1, 8'hDD, 1);
    chk("rst_cnt", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    step(1, 1, 1, 8'h5A, 0);
    step(1, 1, 0, 8'h00, 1);
    step(1, 1, 0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 14: storage depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter AFULL_THRESH, default 2^ADDR_WIDTH-4: almost_full asserts at count >= this value.
REQ-004 Parameter AEMPTY_THRESH, default 4: almost_empty asserts at count <= this value.
REQ-005 clock  input  1  single clock; all logic samples on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 enable  input  1  global qualifier; read and write are ignored while 0.
REQ-008 write  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 read  input  1  read request.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 data_valid  output  1  one-cycle pulse marking new data_out.
REQ-013 full / empty  output  1 each  registered occupancy flags.
REQ-014 almost_full / almost_empty  output  1 each  registered threshold flags.
REQ-015 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-017 Write accepted iff enable=1, write=1, full=0 at the clock edge; data_in is stored at the write pointer, which then increments.
REQ-018 Read accepted iff enable=1, read=1, empty=0 at the clock edge; the word at the read pointer loads into data_out on that edge, data_valid=1 for exactly the next cycle, and the read pointer increments.
REQ-019 Read latency: exactly 1 clock from accepted read to data_out/data_valid.
REQ-020 data_out holds its last value when no read is accepted; data_valid=0.
REQ-021 Pointers are ADDR_WIDTH+1 bits; address uses the low ADDR_WIDTH bits; wrap from DEPTH-1 to 0 is seamless.
REQ-022 count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 Simultaneous read and write: each is judged independently on the registered full/empty; when full, only the read is accepted; when empty, only the write is accepted (no bypass; empty FIFO cannot return data in the same cycle it is written).
REQ-024 Both accepted in one cycle: the flags and count remain unchanged.
REQ-025 Flags are registered and reflect the post-edge count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_THRESH), almost_empty = (count<=AEMPTY_THRESH).
REQ-026 Rejected requests do not alter pointers, count, memory, or data_out.
REQ-027 Storage is a single synchronous-read RAM array suitable for block-RAM inference; memory contents are never reset.

Reset
REQ-028 While reset=0 at a clock edge: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0, data_valid=0, overflow=0, underflow=0.
REQ-029 Reset asserted mid-operation discards all stored words on that edge; requests that coincide with reset are ignored.

Configuration
REQ-030 Macro PARAM_FIFO_ERR_EN defined: overflow sets on any enable&write while full, and underflow sets on any enable&read while empty; both stay at 1 until reset.
REQ-031 Macro PARAM_FIFO_ERR_EN undefined: overflow and underflow are tied to 0 and no error logic is synthesised; all other behaviour is identical.

Verification (bench overrides ADDR_WIDTH=4, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4)
REQ-032 Reset: hold reset=0 for 2 cycles -> empty=1, full=0, count=0, data_out=0, almost_empty=1.
REQ-033 Fill/drain: write 0x01..0x10 with enable=1 -> full=1, count=16, almost_full at count 12; read 16 -> data_out 0x01..0x10 in order, each 1 cycle after its read, empty=1.
REQ-034 Wrap: write 10, read 10, write 16, read 16 -> data is in order across the pointer wrap, and count ends at 0.
REQ-035 Simultaneous: with count=5, read+write for 8 cycles -> count stays 5, output order is preserved; at full, read+write -> count=15; at empty, read+write -> count=1, data_valid=0.
REQ-036 Errors (PARAM_FIFO_ERR_EN defined): write when full -> overflow=1 sticky, count=16 unchanged; read when empty -> underflow=1; when undefined, both stay 0.
REQ-037 Enable/reset: with enable=0, write/read pulses -> no change; reset=0 at count=9 -> next cycle count=0, empty=1.
